// File: rtl/share_alloc_if.sv
// ============================================================================
// share_alloc_if : request/result bundle between the allocator and its user.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface share_alloc_if #(
  parameter int N = 3
);
  logic              start;
  logic [32*N-1:0]   w_flat;
  logic [31:0]       den;
  logic [31:0]       i_total;
  logic              busy;
  logic              share_valid;
  logic [3:0]        share_idx;
  logic [31:0]       share_out;
  logic              sat;
  logic              done;
  logic              err_den0;

  modport master (
    output start, w_flat, den, i_total,
    input  busy, share_valid, share_idx, share_out, sat, done, err_den0
  );

  modport slave (
    input  start, w_flat, den, i_total,
    output busy, share_valid, share_idx, share_out, sat, done, err_den0
  );
endinterface

`default_nettype wire

// File: rtl/share_alloc.sv
// ============================================================================
// share_alloc : sequential per-cell current split, share = floor(total*w/den).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module share_alloc #(
  parameter int N = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  share_alloc_if.slave      bus
);

  localparam logic [3:0] c_LAST = 4'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [32*N-1:0] r_w;
  logic [31:0]     r_den;
  logic [31:0]     r_tot;
  logic [3:0]      r_cell;
  logic [31:0]     r_rem;
  logic [31:0]     r_plo;
  logic [31:0]     r_quot;
  logic [4:0]      r_step;
  logic            r_sat_pend;

  logic            r_busy;
  logic            r_valid;
  logic [3:0]      r_idx;
  logic [31:0]     r_share;
  logic            r_sat;
  logic            r_done;
  logic            r_err;

  logic [31:0]     w_wsel;
  logic [63:0]     w_prod;
  logic            w_den0;
  logic            w_ovf;
  logic            w_last;
  logic [32:0]     w_trial;
  logic            w_ge;
  logic [31:0]     w_diff;
  logic [31:0]     w_rem_nxt;

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cell == 4'(i)) w_wsel = r_w[32*i +: 32];
    end
  end

  assign w_prod    = {32'd0, r_tot} * {32'd0, w_wsel};
  assign w_den0    = (r_den == 32'd0);
  // High half >= den means the quotient cannot fit in 32 bits.
  assign w_ovf     = (w_prod[63:32] >= r_den);
  assign w_last    = (r_cell == c_LAST);

  assign w_trial   = {r_rem, r_plo[31]};
  assign w_ge      = (w_trial >= {1'b0, r_den});
  assign w_diff    = 32'(w_trial - {1'b0, r_den});
  assign w_rem_nxt = w_ge ? w_diff : w_trial[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_MUL;
      S_MUL:  w_state_nxt = (w_den0 || w_ovf) ? S_OUT : S_DIV;
      S_DIV:  if (r_step == 5'd31) w_state_nxt = S_OUT;
      S_OUT:  w_state_nxt = w_last ? S_FIN : S_MUL;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w        <= '0;
      r_den      <= '0;
      r_tot      <= '0;
      r_cell     <= '0;
      r_rem      <= '0;
      r_plo      <= '0;
      r_quot     <= '0;
      r_step     <= '0;
      r_sat_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_share    <= '0;
      r_sat      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_busy  <= (r_state != S_IDLE);
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_w    <= bus.w_flat;
            r_den  <= bus.den;
            r_tot  <= bus.i_total;
            r_cell <= '0;
            r_err  <= (bus.den == 32'd0);
          end
        end
        S_MUL: begin
          r_step <= '0;
          r_rem  <= w_prod[63:32];
          r_plo  <= w_prod[31:0];
          if (w_den0) begin
            r_quot     <= '0;
            r_sat_pend <= 1'b0;
          end else if (w_ovf) begin
            r_quot     <= '1;
            r_sat_pend <= 1'b1;
          end else begin
            r_quot     <= '0;
            r_sat_pend <= 1'b0;
          end
        end
        S_DIV: begin
          r_rem  <= w_rem_nxt;
          r_plo  <= {r_plo[30:0], 1'b0};
          r_quot <= {r_quot[30:0], w_ge};
          r_step <= r_step + 5'd1;
        end
        S_OUT: begin
          r_valid <= 1'b1;
          r_idx   <= r_cell;
          r_share <= r_quot;
          r_sat   <= r_sat_pend;
          if (!w_last) r_cell <= r_cell + 4'd1;
        end
        S_FIN: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.share_valid = r_valid;
  assign bus.share_idx   = r_idx;
  assign bus.share_out   = r_share;
  assign bus.sat         = r_sat;
  assign bus.done        = r_done;
  assign bus.err_den0    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_share_alloc.sv
// ============================================================================
// tb_share_alloc : scoreboard bench for share_alloc (directed + random runs).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_share_alloc;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  share_alloc_if #(.N(N)) bus();

  share_alloc #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] sh;
    logic        sat;
    int unsigned cyc;
  } exp_t;

  exp_t        q_sh[$];
  int unsigned q_done[$];
  int unsigned cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  // Reference: plain 64-bit arithmetic; a quotient of 2^32 or more saturates.
  function automatic void model(input logic [31:0] w, input logic [31:0] d, input logic [31:0] t,
                                output logic [31:0] sh, output logic sat, output int unsigned cost);
    logic [63:0] p;
    logic [63:0] q;
    p = 64'(w) * 64'(t);
    if (d == 32'd0) begin
      sh = '0; sat = 1'b0; cost = 2;
    end else begin
      q = p / 64'(d);
      if (q > 64'h0000_0000_FFFF_FFFF) begin
        sh = '1; sat = 1'b1; cost = 2;
      end else begin
        sh = q[31:0]; sat = 1'b0; cost = 34;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.share_valid) begin
        if (q_sh.size() == 0) begin
          check("unexpected_share_valid", 64'(bus.share_valid), 64'd0);
        end else begin
          exp_t e;
          e = q_sh.pop_front();
          check("share_idx",   64'(bus.share_idx), 64'(e.idx));
          check("share_out",   64'(bus.share_out), 64'(e.sh));
          check("share_sat",   64'(bus.sat),       64'(e.sat));
          check("share_cycle", 64'(cnt),           64'(e.cyc));
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          int unsigned dc;
          dc = q_done.pop_front();
          check("done_cycle", 64'(cnt), 64'(dc));
        end
      end
    end
  end

  task automatic wait_cyc(input int unsigned c);
    while (cnt < c) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle s).
  task automatic launch(input logic [32*N-1:0] wf, input logic [31:0] d, input logic [31:0] t,
                        output int unsigned s);
    int unsigned tc;
    int unsigned cost;
    logic [31:0] sh;
    logic        sat;
    exp_t        e;
    bus.w_flat  = wf;
    bus.den     = d;
    bus.i_total = t;
    bus.start   = 1'b1;
    s  = cnt + 1;
    tc = s;
    for (int k = 0; k < N; k++) begin
      model(wf[32*k +: 32], d, t, sh, sat, cost);
      tc += cost;
      e.idx = k; e.sh = sh; e.sat = sat; e.cyc = tc;
      q_sh.push_back(e);
    end
    q_done.push_back(tc + 1);
    exp_err = (d == 32'd0);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.w_flat  = {$urandom, $urandom, $urandom};
    bus.den     = $urandom;
    bus.i_total = $urandom;
    check("err_den0_at_start", 64'(bus.err_den0), 64'(exp_err));
  endtask

  task automatic wait_done();
    int t = 0;
    while (q_done.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("run_timeout", 64'(q_done.size()), 64'd0);
    check("leftover_shares", 64'(q_sh.size()), 64'd0);
    check("err_den0_after_run", 64'(bus.err_den0), 64'(exp_err));
  endtask

  task automatic pulse_start_junk();
    bus.start  = 1'b1;
    bus.den    = 32'd0;
    bus.w_flat = {$urandom, $urandom, $urandom};
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  initial begin
    int unsigned s;
    logic [32*N-1:0] wf;
    logic [31:0] d;
    logic [31:0] sum;
    int mode;

    rst = 1'b1;
    bus.start = 1'b0; bus.w_flat = '0; bus.den = '0; bus.i_total = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(bus.busy),        64'd0);
    check("rst_valid",  64'(bus.share_valid), 64'd0);
    check("rst_done",   64'(bus.done),        64'd0);
    check("rst_err",    64'(bus.err_den0),    64'd0);
    check("rst_share",  64'(bus.share_out),   64'd0);
    check("rst_idx",    64'(bus.share_idx),   64'd0);
    check("rst_sat",    64'(bus.sat),         64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 50/30/20 split with an ignored start at cycle 10
    launch({32'd20, 32'd30, 32'd50}, 32'd100, 32'd1000, s);
    wait_cyc(s + 9);
    pulse_start_junk();
    wait_done();

    // Truncation case plus busy window edges
    launch({32'd1, 32'd1, 32'd1}, 32'd3, 32'd10, s);
    check("busy_cycle_start", 64'(bus.busy), 64'd0);
    wait_cyc(s + 1);
    check("busy_first", 64'(bus.busy), 64'd1);
    wait_cyc(s + 103);
    check("busy_last", 64'(bus.busy), 64'd1);
    wait_cyc(s + 104);
    check("busy_after", 64'(bus.busy), 64'd0);
    wait_done();

    // Zero denominator: short path and sticky error
    launch({32'd7, 32'd8, 32'd9}, 32'd0, 32'd500, s);
    wait_done();
    repeat (3) @(negedge clk);
    check("err_den0_sticky", 64'(bus.err_den0), 64'd1);

    // Saturating first cell, normal others
    launch({32'd20, 32'd30, 32'd200}, 32'd100, 32'hFFFF_FFFF, s);
    wait_done();

    // Reset mid-run, then restart at cycle 55
    launch({32'd20, 32'd30, 32'd50}, 32'd100, 32'd1000, s);
    wait_cyc(s + 50);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy",  64'(bus.busy),        64'd0);
    check("midrst_valid", 64'(bus.share_valid), 64'd0);
    check("midrst_done",  64'(bus.done),        64'd0);
    check("midrst_err",   64'(bus.err_den0),    64'd0);
    check("midrst_share", 64'(bus.share_out),   64'd0);
    q_sh.delete();
    q_done.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(s + 54);
    launch({32'd20, 32'd30, 32'd50}, 32'd100, 32'd1000, s);
    wait_done();

    // Randomized runs with a junk start shortly after each accept
    for (int r = 0; r < 10; r++) begin
      sum = 0;
      for (int k = 0; k < N; k++) begin
        wf[32*k +: 32] = $urandom_range(0, 32'h0010_0000);
        sum += wf[32*k +: 32];
      end
      mode = $urandom_range(0, 3);
      case (mode)
        0:       d = sum;
        1:       d = $urandom;
        2:       d = 32'd0;
        default: d = $urandom_range(1, 50);
      endcase
      launch(wf, d, $urandom, s);
      wait_cyc(s + 2);
      pulse_start_junk();
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
